rcu_dribbler: RTL and testbench

Background spill/fill engine for the 64-entry stack cache register file in the RCU. It compares the pipeline's top-of-stack pointer against its own stack-cache bottom pointer. When the cache runs too full, it spills the oldest entry to the data cache. When it runs too empty, it fills the next older entry back from the data cache. It uses one read port (port C) and one write port (port E) of the register file, and a single-outstanding request/ack interface to the data cache.

---
 rtl/rcu_pkg.sv | 16 +
 rtl/rcu_sc_count.sv | 30 +++
 rtl/rcu_dribbler.sv | 139 +++++++++++++
 tb/tb_rcu_dribbler.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rcu_pkg.sv
// Shared types and sizes for the RCU stack-cache dribbler and its entry counter.
package rcu_pkg;

    localparam int SC_ENTRIES = 64;
    localparam int SC_IDX_W   = 6;
    localparam int SC_CNT_W   = 7;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SPILL_RD  = 3'd1,
        SPILL_REQ = 3'd2,
        FILL_REQ  = 3'd3,
        FILL_WR   = 3'd4
    } dribble_state_t;

endpackage

// File: rtl/rcu_sc_count.sv
// Stack-cache occupancy: words between optop and the cache bottom, saturated,
// plus the full-cache stall flag.
module rcu_sc_count
    import rcu_pkg::*;
(
    input  logic [31:0]         i_optop,
    input  logic [31:0]         i_sc_bottom,
    output logic [SC_CNT_W-1:0] o_cnt,
    output logic                o_sc_stall
);

    logic [29:0] w_diff;

    // Addresses are word aligned, so the word count is the difference of the word indexes.
    assign w_diff = i_sc_bottom[31:2] - i_optop[31:2];

    always_comb begin
        o_cnt = '0;
        if (i_optop > i_sc_bottom) begin
            o_cnt = '0;
        end else if (|w_diff[29:SC_CNT_W]) begin
            o_cnt = '1;
        end else begin
            o_cnt = w_diff[SC_CNT_W-1:0];
        end
    end

    assign o_sc_stall = (o_cnt >= SC_CNT_W'(SC_ENTRIES));

endmodule

// File: rtl/rcu_dribbler.sv
// Background spill/fill engine keeping the 64-entry stack cache between its
// low and high water marks through a single-outstanding data-cache port.
module rcu_dribbler
    import rcu_pkg::*;
#(
    parameter int unsigned HI_MARK       = 48,
    parameter int unsigned LO_MARK       = 8,
    parameter logic [31:0] SC_BOTTOM_RST = 32'h0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                dribble_en,
    input  logic [31:0]         optop,
    input  logic [31:0]         stack_base,
    input  logic                bottom_ld,
    input  logic [31:0]         bottom_ld_data,
    output logic [SC_IDX_W-1:0] rf_rd_addr,
    input  logic [31:0]         rf_rd_data,
    output logic [SC_IDX_W-1:0] rf_wr_addr,
    output logic [31:0]         rf_wr_data,
    output logic                rf_wr_en,
    output logic                dc_req,
    output logic                dc_we,
    output logic [31:0]         dc_addr,
    output logic [31:0]         dc_wdata,
    input  logic                dc_ack,
    input  logic [31:0]         dc_rdata,
    output logic [31:0]         sc_bottom,
    output logic                busy,
    output logic                sc_stall
);

    localparam logic [SC_CNT_W-1:0] HI_CNT = SC_CNT_W'(HI_MARK);
    localparam logic [SC_CNT_W-1:0] LO_CNT = SC_CNT_W'(LO_MARK);

    dribble_state_t      r_state;
    logic [31:0]         r_sc_bottom;
    logic [SC_IDX_W-1:0] r_rd_addr;
    logic [SC_IDX_W-1:0] r_wr_addr;
    logic [31:0]         r_wr_data;
    logic                r_wr_en;
    logic                r_dc_req;
    logic                r_dc_we;
    logic [31:0]         r_dc_addr;
    logic [31:0]         r_dc_wdata;

    logic [SC_CNT_W-1:0] w_cnt;
    logic [31:0]         w_bot_m4;
    logic                w_start_spill;
    logic                w_start_fill;

    rcu_sc_count u_count (
        .i_optop     (optop),
        .i_sc_bottom (r_sc_bottom),
        .o_cnt       (w_cnt),
        .o_sc_stall  (sc_stall)
    );

    assign w_bot_m4      = r_sc_bottom - 32'd4;
    assign w_start_spill = dribble_en && (w_cnt > HI_CNT);
    assign w_start_fill  = dribble_en && (w_cnt < LO_CNT) && (r_sc_bottom < stack_base)
                           && (optop <= r_sc_bottom);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_sc_bottom <= SC_BOTTOM_RST;
            r_rd_addr   <= '0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_wr_en     <= 1'b0;
            r_dc_req    <= 1'b0;
            r_dc_we     <= 1'b0;
            r_dc_addr   <= '0;
            r_dc_wdata  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    // A bottom reload wins over starting an operation in the same cycle.
                    if (bottom_ld) begin
                        r_sc_bottom <= bottom_ld_data;
                    end else if (w_start_spill) begin
                        r_rd_addr <= w_bot_m4[7:2];
                        r_state   <= SPILL_RD;
                    end else if (w_start_fill) begin
                        r_dc_req  <= 1'b1;
                        r_dc_we   <= 1'b0;
                        r_dc_addr <= r_sc_bottom;
                        r_state   <= FILL_REQ;
                    end
                end
                SPILL_RD: begin
                    r_dc_wdata <= rf_rd_data;
                    r_dc_req   <= 1'b1;
                    r_dc_we    <= 1'b1;
                    r_dc_addr  <= w_bot_m4;
                    r_state    <= SPILL_REQ;
                end
                SPILL_REQ: begin
                    if (dc_ack) begin
                        r_dc_req    <= 1'b0;
                        r_dc_we     <= 1'b0;
                        r_sc_bottom <= w_bot_m4;
                        r_state     <= IDLE;
                    end
                end
                FILL_REQ: begin
                    if (dc_ack) begin
                        r_dc_req  <= 1'b0;
                        r_wr_data <= dc_rdata;
                        r_wr_addr <= r_sc_bottom[7:2];
                        r_wr_en   <= 1'b1;
                        r_state   <= FILL_WR;
                    end
                end
                FILL_WR: begin
                    r_wr_en     <= 1'b0;
                    r_sc_bottom <= r_sc_bottom + 32'd4;
                    r_state     <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign rf_rd_addr = r_rd_addr;
    assign rf_wr_addr = r_wr_addr;
    assign rf_wr_data = r_wr_data;
    assign rf_wr_en   = r_wr_en;
    assign dc_req     = r_dc_req;
    assign dc_we      = r_dc_we;
    assign dc_addr    = r_dc_addr;
    assign dc_wdata   = r_dc_wdata;
    assign sc_bottom  = r_sc_bottom;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_rcu_dribbler.sv
// Bench for rcu_dribbler: register-file and data-cache models, a scoreboard of
// expected cache/regfile transactions, and a table of occupancy/stall vectors.
module tb_rcu_dribbler;

    logic        clk = 1'b0;
    logic        reset;
    logic        dribble_en;
    logic [31:0] optop;
    logic [31:0] stack_base;
    logic        bottom_ld;
    logic [31:0] bottom_ld_data;
    logic [5:0]  rf_rd_addr;
    logic [31:0] rf_rd_data;
    logic [5:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;
    logic        rf_wr_en;
    logic        dc_req;
    logic        dc_we;
    logic [31:0] dc_addr;
    logic [31:0] dc_wdata;
    logic        dc_ack;
    logic [31:0] dc_rdata;
    logic [31:0] sc_bottom;
    logic        busy;
    logic        sc_stall;

    int n_vec = 0;
    int n_err = 0;

    rcu_dribbler #(.HI_MARK(48), .LO_MARK(8), .SC_BOTTOM_RST(32'h0)) dut (
        .clk            (clk),
        .reset          (reset),
        .dribble_en     (dribble_en),
        .optop          (optop),
        .stack_base     (stack_base),
        .bottom_ld      (bottom_ld),
        .bottom_ld_data (bottom_ld_data),
        .rf_rd_addr     (rf_rd_addr),
        .rf_rd_data     (rf_rd_data),
        .rf_wr_addr     (rf_wr_addr),
        .rf_wr_data     (rf_wr_data),
        .rf_wr_en       (rf_wr_en),
        .dc_req         (dc_req),
        .dc_we          (dc_we),
        .dc_addr        (dc_addr),
        .dc_wdata       (dc_wdata),
        .dc_ack         (dc_ack),
        .dc_rdata       (dc_rdata),
        .sc_bottom      (sc_bottom),
        .busy           (busy),
        .sc_stall       (sc_stall)
    );

    always #5 clk = ~clk;

    // Register file model: combinational read, write on the clock edge.
    logic [31:0] rf_mem [64];
    assign rf_rd_data = rf_mem[rf_rd_addr];
    always @(posedge clk) if (rf_wr_en) rf_mem[rf_wr_addr] <= rf_wr_data;

    // Data cache model: ack after ack_wait cycles of request; load data from the address.
    bit ack_en   = 1'b1;
    int ack_wait = 0;
    int req_age  = 0;
    assign dc_ack   = ack_en && dc_req && (req_age >= ack_wait);
    assign dc_rdata = 32'hA5A5_0001 + {28'h0, dc_addr[5:2]};
    always @(posedge clk) begin
        if (!dc_req || dc_ack) req_age <= 0;
        else                   req_age <= req_age + 1;
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t dc_exp[$];
    txn_t rf_exp[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    // Scoreboard: pop an expectation for every accepted cache request and every regfile write.
    always @(negedge clk) begin
        if (!reset && dc_req && dc_ack) begin
            if (dc_exp.size() == 0) begin
                check("dc_unexpected_req", dc_addr, 32'hDEAD_DEAD);
            end else begin
                txn_t e;
                e = dc_exp.pop_front();
                check("dc_we", {31'h0, dc_we}, {31'h0, e.we});
                check("dc_addr", dc_addr, e.addr);
                if (e.we) check("dc_wdata", dc_wdata, e.data);
            end
        end
        if (!reset && rf_wr_en) begin
            if (rf_exp.size() == 0) begin
                check("rf_unexpected_wr", {26'h0, rf_wr_addr}, 32'hDEAD_DEAD);
            end else begin
                txn_t e;
                e = rf_exp.pop_front();
                check("rf_wr_addr", {26'h0, rf_wr_addr}, e.addr);
                check("rf_wr_data", rf_wr_data, e.data);
            end
        end
    end

    task automatic push_dc(input logic we, input logic [31:0] addr, input logic [31:0] data);
        txn_t t;
        t.we = we; t.addr = addr; t.data = data;
        dc_exp.push_back(t);
    endtask

    task automatic push_rf(input logic [31:0] addr, input logic [31:0] data);
        txn_t t;
        t.we = 1'b1; t.addr = addr; t.data = data;
        rf_exp.push_back(t);
    endtask

    task automatic do_reset();
        dribble_en = 1'b0; bottom_ld = 1'b0; bottom_ld_data = '0;
        optop = '0; stack_base = '0; ack_en = 1'b1; ack_wait = 0;
        dc_exp.delete(); rf_exp.delete();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); @(negedge clk); reset = 1'b0;
    endtask

    task automatic load_bottom(input logic [31:0] b);
        @(negedge clk); bottom_ld = 1'b1; bottom_ld_data = b;
        @(negedge clk); bottom_ld = 1'b0;
    endtask

    task automatic wait_req(input string name, input logic [31:0] addr);
        bit seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (dc_req && dc_addr == addr) begin seen = 1'b1; break; end
        end
        if (!seen) check({name, "_timeout"}, 32'h0, 32'h1);
    endtask

    task automatic check_drained(input string name);
        check({name, "_dc_left"}, dc_exp.size(), 32'h0);
        check({name, "_rf_left"}, rf_exp.size(), 32'h0);
    endtask

    typedef struct {
        logic [31:0] bottom;
        logic [31:0] top;
        logic        exp_stall;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [31:0] hold_addr, hold_wdata;

        vecs[0] = '{32'h0000_1000, 32'h0000_0F00, 1'b1};  // 64 entries
        vecs[1] = '{32'h0000_1000, 32'h0000_0F04, 1'b0};  // 63 entries
        vecs[2] = '{32'h0000_1000, 32'h0000_1004, 1'b0};  // optop above bottom
        vecs[3] = '{32'h0000_1000, 32'h0000_1000, 1'b0};  // empty
        vecs[4] = '{32'h0000_1000, 32'h0000_0000, 1'b1};  // saturates
        vecs[5] = '{32'h0000_0010, 32'hFFFF_FF00, 1'b0};  // optop far above
        vecs[6] = '{32'h8000_0000, 32'h7FFF_FE00, 1'b1};  // 128 entries, saturates

        for (int i = 0; i < 64; i++) rf_mem[i] = 32'hC0DE_0000 + 32'(i);
        reset = 1'b0;
        do_reset();

        check("rst_sc_bottom", sc_bottom, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_dc_req", {31'h0, dc_req}, 32'h0);
        check("rst_dc_addr", dc_addr, 32'h0);
        check("rst_rf_wr_en", {31'h0, rf_wr_en}, 32'h0);
        check("rst_sc_stall", {31'h0, sc_stall}, 32'h0);

        // Occupancy / stall table.
        for (int i = 0; i < 7; i++) begin
            load_bottom(vecs[i].bottom);
            optop = vecs[i].top;
            #1;
            check($sformatf("stall_vec%0d", i), {31'h0, sc_stall}, {31'h0, vecs[i].exp_stall});
        end

        // No fill when optop sits above the bottom.
        do_reset();
        load_bottom(32'h1000); optop = 32'h1004; stack_base = 32'h2000; dribble_en = 1'b1;
        repeat (6) @(negedge clk);
        check("wrap_no_fill_busy", {31'h0, busy}, 32'h0);
        check("wrap_no_fill_req", {31'h0, dc_req}, 32'h0);

        // Two spills down to the high mark.
        do_reset();
        load_bottom(32'h1000); optop = 32'h1000 - 32'd200; stack_base = 32'h2000;
        push_dc(1'b1, 32'h0FFC, 32'hC0DE_003F);
        push_dc(1'b1, 32'h0FF8, 32'hC0DE_003E);
        dribble_en = 1'b1;
        repeat (20) @(negedge clk);
        check("spill_sc_bottom", sc_bottom, 32'h0FF8);
        check("spill_idle", {31'h0, busy}, 32'h0);
        check_drained("spill");

        // Two fills, then dribble_en drops during the second one.
        do_reset();
        load_bottom(32'h1000); optop = 32'h0FF0; stack_base = 32'h1010;
        push_dc(1'b0, 32'h1000, 32'h0); push_rf(32'h00, 32'hA5A5_0001);
        push_dc(1'b0, 32'h1004, 32'h0); push_rf(32'h01, 32'hA5A5_0002);
        dribble_en = 1'b1;
        wait_req("fill2", 32'h1004);
        dribble_en = 1'b0;
        repeat (10) @(negedge clk);
        check("fill_sc_bottom", sc_bottom, 32'h1008);
        check("fill_rf_mem1", rf_mem[1], 32'hA5A5_0002);
        check_drained("fill");

        // Fill limited by stack_base: exactly one fill.
        do_reset();
        load_bottom(32'h1000); optop = 32'h0FF0; stack_base = 32'h1004;
        push_dc(1'b0, 32'h1000, 32'h0); push_rf(32'h00, 32'hA5A5_0001);
        dribble_en = 1'b1;
        repeat (15) @(negedge clk);
        check("limit_sc_bottom", sc_bottom, 32'h1004);
        check("limit_idle", {31'h0, busy}, 32'h0);
        check_drained("limit");

        // Ack held off for 5 cycles: request fields must hold steady.
        do_reset();
        load_bottom(32'h1000); optop = 32'h1000 - 32'd196; stack_base = 32'h2000; ack_wait = 5;
        push_dc(1'b1, 32'h0FFC, 32'hC0DE_003F);
        dribble_en = 1'b1;
        wait_req("ackwait", 32'h0FFC);
        hold_addr = 32'h0FFC; hold_wdata = 32'hC0DE_003F;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("ackwait_req_c%0d", i), {31'h0, dc_req}, 32'h1);
            check($sformatf("ackwait_addr_c%0d", i), dc_addr, hold_addr);
            check($sformatf("ackwait_wdata_c%0d", i), dc_wdata, hold_wdata);
            check($sformatf("ackwait_bottom_c%0d", i), sc_bottom, 32'h1000);
            if (i < 5) @(negedge clk);
        end
        @(negedge clk);
        check("ackwait_req_drop", {31'h0, dc_req}, 32'h0);
        check("ackwait_bottom_after", sc_bottom, 32'h0FFC);
        repeat (5) @(negedge clk);
        check_drained("ackwait");

        // Reset in the middle of a spill handshake.
        do_reset();
        load_bottom(32'h1000); optop = 32'h1000 - 32'd200; stack_base = 32'h2000; ack_en = 1'b0;
        dribble_en = 1'b1;
        wait_req("rstmid", 32'h0FFC);
        reset = 1'b1;
        #1;
        check("rstmid_dc_req", {31'h0, dc_req}, 32'h0);
        check("rstmid_sc_bottom", sc_bottom, 32'h0);
        check("rstmid_busy", {31'h0, busy}, 32'h0);
        dribble_en = 1'b0;
        @(negedge clk); reset = 1'b0;

        // bottom_ld during a busy spill is ignored.
        do_reset();
        load_bottom(32'h1000); optop = 32'h1000 - 32'd196; stack_base = 32'h2000; ack_wait = 3;
        push_dc(1'b1, 32'h0FFC, 32'hC0DE_003F);
        dribble_en = 1'b1;
        wait_req("ldbusy", 32'h0FFC);
        bottom_ld = 1'b1; bottom_ld_data = 32'h5000;
        @(negedge clk); bottom_ld = 1'b0;
        repeat (12) @(negedge clk);
        check("ldbusy_sc_bottom", sc_bottom, 32'h0FFC);
        check_drained("ldbusy");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule
